// File: rtl/hazard_ctrl.sv
// Stall-side hazard controller: compares D-stage operand demand against E/M producer shadows.
// Optional MD_STALL_EN macro adds the mult/div busy counter and HI/LO stall term.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic [4:0] A3_D,
    input  logic       RFWr_D,
    input  logic [1:0] Tnew_D,
    input  logic       MDStart_D,
    input  logic       MDDiv_D,
    input  logic       HILOUse_D,
    output logic       stall,
    output logic       md_busy,
    output logic [1:0] Tnew_E,
    output logic [1:0] Tnew_M
);

    logic [4:0] a3_e, a3_m;
    logic       rfwr_e, rfwr_m;
    logic [1:0] tnew_e, tnew_m;
    logic       haz_rs, haz_rt, haz_md;

    function automatic logic [1:0] tnew_sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Address match already implies a nonzero destination, so A3=0 producers never stall.
    assign haz_rs = (A1_D != 5'd0) &&
                    (((A1_D == a3_e) && rfwr_e && (tnew_e > Tuse_rs_D)) ||
                     ((A1_D == a3_m) && rfwr_m && (tnew_m > Tuse_rs_D)));
    assign haz_rt = (A2_D != 5'd0) &&
                    (((A2_D == a3_e) && rfwr_e && (tnew_e > Tuse_rt_D)) ||
                     ((A2_D == a3_m) && rfwr_m && (tnew_m > Tuse_rt_D)));

    assign stall  = haz_rs | haz_rt | haz_md;
    assign Tnew_E = tnew_e;
    assign Tnew_M = tnew_m;

    // E/M shadow stage boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            a3_e   <= 5'd0;
            rfwr_e <= 1'b0;
            tnew_e <= 2'd0;
            a3_m   <= 5'd0;
            rfwr_m <= 1'b0;
            tnew_m <= 2'd0;
        end else begin
            if (stall) begin
                a3_e   <= 5'd0;
                rfwr_e <= 1'b0;
                tnew_e <= 2'd0;
            end else begin
                a3_e   <= A3_D;
                rfwr_e <= RFWr_D;
                tnew_e <= Tnew_D;
            end
            a3_m   <= a3_e;
            rfwr_m <= rfwr_e;
            tnew_m <= tnew_sat_dec(tnew_e);
        end
    end

`ifdef MD_STALL_EN
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [MD_W-1:0] md_cnt;

    // A load only happens with md_busy=0, so load and decrement never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (MDStart_D && !stall) begin
            md_cnt <= MDDiv_D ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    assign md_busy = (md_cnt != '0);
    assign haz_md  = (HILOUse_D | MDStart_D) & md_busy;
`else
    localparam int unused_md_cycles = MULT_CYCLES + DIV_CYCLES;

    logic unused_md_inputs;
    assign unused_md_inputs = ^{MDStart_D, MDDiv_D, HILOUse_D};
    assign md_busy          = 1'b0;
    assign haz_md           = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expected {stall, md_busy, Tnew_E, Tnew_M}.
module tb_hazard_ctrl;

`ifdef MD_STALL_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] a1;
        logic [1:0] tus;
        logic [4:0] a2;
        logic [1:0] tut;
        logic [4:0] a3;
        logic       rfwr;
        logic [1:0] tnew;
        logic       mds;
        logic       mdd;
        logic       hilo;
        logic       rst;
    } stim_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] A1_D, A2_D, A3_D;
    logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
    logic       RFWr_D, MDStart_D, MDDiv_D, HILOUse_D;
    logic       stall, md_busy;
    logic [1:0] Tnew_E, Tnew_M;

    int n_checks = 0;
    int n_err    = 0;

    stim_t      sq[$];
    logic [5:0] eq[$];

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .A1_D(A1_D), .A2_D(A2_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .A3_D(A3_D), .RFWr_D(RFWr_D), .Tnew_D(Tnew_D),
        .MDStart_D(MDStart_D), .MDDiv_D(MDDiv_D), .HILOUse_D(HILOUse_D),
        .stall(stall), .md_busy(md_busy), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M)
    );

    always #5 clk = ~clk;

    function automatic stim_t ins(input logic [4:0] a1, input logic [1:0] tus,
                                  input logic [4:0] a2, input logic [1:0] tut,
                                  input logic [4:0] a3, input logic rfwr,
                                  input logic [1:0] tnew);
        stim_t s;
        s = '0;
        s.a1 = a1; s.tus = tus; s.a2 = a2; s.tut = tut;
        s.a3 = a3; s.rfwr = rfwr; s.tnew = tnew;
        return s;
    endfunction

    function automatic logic [5:0] ex(input logic s, input logic b,
                                      input logic [1:0] te, input logic [1:0] tm);
        return {s, b, te, tm};
    endfunction

    function automatic void add(input stim_t s, input logic [5:0] e);
        sq.push_back(s);
        eq.push_back(e);
    endfunction

    task automatic apply(input stim_t s);
        reset = s.rst;
        A1_D = s.a1; Tuse_rs_D = s.tus; A2_D = s.a2; Tuse_rt_D = s.tut;
        A3_D = s.a3; RFWr_D = s.rfwr; Tnew_D = s.tnew;
        MDStart_D = s.mds; MDDiv_D = s.mdd; HILOUse_D = s.hilo;
    endtask

    stim_t NOP, LW8, ADDU, BEQ8, BEQ_RT8, MFHI;

    task automatic do_reset();
        stim_t s;
        s = NOP;
        s.rst = 1'b1;
        apply(s);
        @(posedge clk); #1;
        apply(NOP);
    endtask

    task automatic test_reset();
        stim_t s;
        logic [5:0] got, e;
        do_reset();
        s = LW8; s.rst = 1'b1;
        add(s, ex(0, 0, 2'd0, 2'd0));
        add(BEQ8, ex(0, 0, 2'd0, 2'd0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            @(negedge clk);
            got = {stall, md_busy, Tnew_E, Tnew_M};
            e = eq.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset cycle %0d: got stall/busy/te/tm=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         i, got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
            end
            @(posedge clk); #1;
        end
        sq.delete();
    endtask

    task automatic test_load_use();
        logic [5:0] got, e;
        do_reset();
        add(LW8,  ex(0, 0, 2'd0, 2'd0));
        add(ADDU, ex(1, 0, 2'd2, 2'd0));
        add(ADDU, ex(0, 0, 2'd0, 2'd1));
        add(NOP,  ex(0, 0, 2'd1, 2'd0));
        add(NOP,  ex(0, 0, 2'd0, 2'd0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            @(negedge clk);
            got = {stall, md_busy, Tnew_E, Tnew_M};
            e = eq.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL load_use cycle %0d: got stall/busy/te/tm=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         i, got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
            end
            @(posedge clk); #1;
        end
        sq.delete();
    endtask

    task automatic test_branch_after_load();
        logic [5:0] got, e;
        do_reset();
        add(LW8,  ex(0, 0, 2'd0, 2'd0));
        add(BEQ8, ex(1, 0, 2'd2, 2'd0));
        add(BEQ8, ex(1, 0, 2'd0, 2'd1));
        add(BEQ8, ex(0, 0, 2'd0, 2'd0));
        add(NOP,  ex(0, 0, 2'd0, 2'd0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            @(negedge clk);
            got = {stall, md_busy, Tnew_E, Tnew_M};
            e = eq.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL branch_load cycle %0d: got stall/busy/te/tm=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         i, got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
            end
            @(posedge clk); #1;
        end
        sq.delete();
    endtask

    task automatic test_zero_nowrite();
        logic [5:0] got, e;
        do_reset();
        add(ins(5'd29, 2'd1, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2), ex(0, 0, 2'd0, 2'd0));
        add(ins(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0),  ex(0, 0, 2'd2, 2'd0));
        add(NOP, ex(0, 0, 2'd0, 2'd1));
        add(ins(5'd29, 2'd1, 5'd8, 2'd2, 5'd8, 1'b0, 2'd2), ex(0, 0, 2'd0, 2'd0));
        add(BEQ_RT8, ex(0, 0, 2'd2, 2'd0));
        add(BEQ_RT8, ex(0, 0, 2'd0, 2'd1));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            @(negedge clk);
            got = {stall, md_busy, Tnew_E, Tnew_M};
            e = eq.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL zero_nowrite cycle %0d: got stall/busy/te/tm=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         i, got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
            end
            @(posedge clk); #1;
        end
        sq.delete();
    endtask

    task automatic test_rt_from_m();
        logic [5:0] got, e;
        do_reset();
        add(LW8,     ex(0, 0, 2'd0, 2'd0));
        add(NOP,     ex(0, 0, 2'd2, 2'd0));
        add(BEQ_RT8, ex(1, 0, 2'd0, 2'd1));
        add(BEQ_RT8, ex(0, 0, 2'd0, 2'd0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            @(negedge clk);
            got = {stall, md_busy, Tnew_E, Tnew_M};
            e = eq.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL rt_from_m cycle %0d: got stall/busy/te/tm=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         i, got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
            end
            @(posedge clk); #1;
        end
        sq.delete();
    endtask

    task automatic test_md(input bit div);
        stim_t s;
        logic [5:0] got, e;
        int cyc;
        logic on;
        cyc = div ? 10 : 5;
        do_reset();
        s = ins(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 1'b0, 2'd0);
        s.mds = 1'b1; s.mdd = div;
        add(s, ex(0, 0, 2'd0, 2'd0));
        for (int k = 1; k <= cyc + 1; k++) begin
            on = MD_ON && (k <= cyc);
            add(MFHI, ex(on, on, (!MD_ON && k >= 2) ? 2'd1 : 2'd0, 2'd0));
        end
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            @(negedge clk);
            got = {stall, md_busy, Tnew_E, Tnew_M};
            e = eq.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL md div=%0b cycle %0d: got stall/busy/te/tm=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         div, i, got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
            end
            @(posedge clk); #1;
        end
        sq.delete();
    endtask

    task automatic test_back_to_back();
        stim_t s;
        logic [5:0] got, e;
        do_reset();
        s = ins(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 1'b0, 2'd0);
        s.mds = 1'b1;
        add(s, ex(0, 0, 2'd0, 2'd0));
        for (int k = 1; k <= 5; k++) add(s, ex(MD_ON, MD_ON, 2'd0, 2'd0));
        add(s,   ex(0, 0, 2'd0, 2'd0));
        add(NOP, ex(0, MD_ON, 2'd0, 2'd0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            @(negedge clk);
            got = {stall, md_busy, Tnew_E, Tnew_M};
            e = eq.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d: got stall/busy/te/tm=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         i, got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
            end
            @(posedge clk); #1;
        end
        sq.delete();
    endtask

    task automatic test_reset_mid_md();
        stim_t s;
        logic [5:0] got, e;
        do_reset();
        s = ins(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 1'b0, 2'd0);
        s.mds = 1'b1; s.mdd = 1'b1;
        add(s, ex(0, 0, 2'd0, 2'd0));
        for (int k = 1; k <= 3; k++) add(NOP, ex(0, MD_ON, 2'd0, 2'd0));
        s = MFHI; s.rst = 1'b1;
        add(s,    ex(MD_ON, MD_ON, 2'd0, 2'd0));
        add(MFHI, ex(0, 0, 2'd0, 2'd0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            @(negedge clk);
            got = {stall, md_busy, Tnew_E, Tnew_M};
            e = eq.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset_mid_md cycle %0d: got stall/busy/te/tm=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         i, got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
            end
            @(posedge clk); #1;
        end
        sq.delete();
    endtask

    initial begin
        NOP     = ins(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        LW8     = ins(5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2);
        ADDU    = ins(5'd8, 2'd1, 5'd8, 2'd1, 5'd9, 1'b1, 2'd1);
        BEQ8    = ins(5'd8, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        BEQ_RT8 = ins(5'd0, 2'd0, 5'd8, 2'd0, 5'd0, 1'b0, 2'd0);
        MFHI    = ins(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1);
        MFHI.hilo = 1'b1;
        apply(NOP);
        reset = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_load_use();
        test_branch_after_load();
        test_zero_nowrite();
        test_rt_from_m();
        test_md(1'b0);
        test_md(1'b1);
        test_back_to_back();
        test_reset_mid_md();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
